lif_param_loader: RTL and testbench

Parametrised serial configuration loader for the leaky-integrate-fire neuron datapath. It shifts in NCH independent parameter fields (e.g. tau, weight, threshold), one bit per lane per clock, into shadow registers. On a well-formed frame it commits them atomically to the active parameter bus. Malformed frames are rejected without disturbing the active values. It sits between the external configuration pins and the neuron core, generalising the fixed 3×8-bit loader to arbitrary width and field count, with frame checking.

---
 rtl/lif_param_loader_if.sv | 24 ++
 rtl/lif_param_loader.sv | 169 ++++++++++++++++
 tb/tb_lif_param_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lif_param_loader_if.sv
// Serial configuration bus for lif_param_loader: frame strobe and per-lane data in,
// active parameter bus and frame status out.
interface lif_param_loader_if #(
    parameter int W   = 8,
    parameter int NCH = 3
);
    logic               load_en;
    logic [NCH-1:0]     sdata;
    logic [NCH*W-1:0]   params;
    logic               upd;
    logic               err;
    logic               err_sticky;
    logic               busy;

    modport master (
        output load_en, sdata,
        input  params, upd, err, err_sticky, busy
    );

    modport slave (
        input  load_en, sdata,
        output params, upd, err, err_sticky, busy
    );
endinterface

// File: rtl/lif_param_loader.sv
// Serial LIF parameter loader: NCH lanes shifted MSB-first into shadows, committed atomically.
// Optional per-lane even-parity trailer bit enabled by `define PARITY_CHECK_EN.

// One lane: shadow shift register plus its active parameter register.
module lif_param_lane #(
    parameter int W  = 8,
    parameter int SW = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         shift_i,
    input  logic         clr_i,
    input  logic         commit_i,
    input  logic         sdi_i,
`ifdef PARITY_CHECK_EN
    output logic         par_ok_o,
`endif
    output logic [W-1:0] param_o
);
    logic [SW-1:0] shadow_q, shadow_d;
    logic [W-1:0]  param_q, param_d;
    logic [W-1:0]  data_w;

`ifdef PARITY_CHECK_EN
    // Trailer bit sits in the LSB; data plus parity must XOR to zero.
    assign data_w   = shadow_q[W:1];
    assign par_ok_o = ~^shadow_q;
`else
    assign data_w   = shadow_q[W-1:0];
`endif

    always_comb begin
        shadow_d = shadow_q;
        if (clr_i)        shadow_d = '0;
        else if (start_i) shadow_d = SW'(sdi_i);
        else if (shift_i) shadow_d = {shadow_q[SW-2:0], sdi_i};
        param_d = commit_i ? data_w : param_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= '0;
            param_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            param_q  <= param_d;
        end
    end

    assign param_o = param_q;
endmodule

module lif_param_loader #(
    parameter int W   = 8,
    parameter int NCH = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    lif_param_loader_if.slave    bus
);
`ifdef PARITY_CHECK_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif
    localparam int CW = $clog2(W + 2);
    localparam logic [CW-1:0] FLEN_C = CW'(FLEN);

    typedef enum logic {S_IDLE, S_SHIFT} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             upd_q, upd_d;
    logic             err_q, err_d;
    logic             stk_q, stk_d;

    logic             start, shift, clr, good, commit, busy;
    logic [NCH-1:0][W-1:0] params_w;
`ifdef PARITY_CHECK_EN
    logic [NCH-1:0]   par_ok_w;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.load_en)  state_d = S_SHIFT;
            S_SHIFT: if (!bus.load_en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start = (state_q == S_IDLE) && bus.load_en;
        shift = (state_q == S_SHIFT) && bus.load_en && (cnt_q < FLEN_C);
        clr   = (state_q == S_SHIFT) && !bus.load_en;
        busy  = (state_q == S_SHIFT);
`ifdef PARITY_CHECK_EN
        good  = (cnt_q == FLEN_C) && !ovr_q && (&par_ok_w);
`else
        good  = (cnt_q == FLEN_C) && !ovr_q;
`endif
        commit = clr && good;
    end

    // Counter saturates at FLEN; anything beyond that only marks overrun.
    always_comb begin
        cnt_d = cnt_q;
        ovr_d = ovr_q;
        if (start) begin
            cnt_d = CW'(1);
            ovr_d = 1'b0;
        end else if (shift) begin
            cnt_d = cnt_q + CW'(1);
        end else if (busy && bus.load_en) begin
            ovr_d = 1'b1;
        end else if (clr) begin
            cnt_d = '0;
            ovr_d = 1'b0;
        end
        upd_d = commit;
        err_d = clr && !good;
        stk_d = commit ? 1'b0 : (err_d ? 1'b1 : stk_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ovr_q <= 1'b0;
            upd_q <= 1'b0;
            err_q <= 1'b0;
            stk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
            upd_q <= upd_d;
            err_q <= err_d;
            stk_q <= stk_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        lif_param_lane #(.W(W), .SW(FLEN)) u_lane (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .start_i  (start),
            .shift_i  (shift),
            .clr_i    (clr),
            .commit_i (commit),
            .sdi_i    (bus.sdata[i]),
`ifdef PARITY_CHECK_EN
            .par_ok_o (par_ok_w[i]),
`endif
            .param_o  (params_w[i])
        );
    end

    assign bus.params     = params_w;
    assign bus.upd        = upd_q;
    assign bus.err        = err_q;
    assign bus.err_sticky = stk_q;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_lif_param_loader.sv
// Directed bench for lif_param_loader (W=8, NCH=3); parity cases run when PARITY_CHECK_EN is defined.
module tb_lif_param_loader;
    localparam int W   = 8;
    localparam int NCH = 3;
`ifdef PARITY_CHECK_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   busy_cnt;

    lif_param_loader_if #(.W(W), .NCH(NCH)) bus ();

    lif_param_loader #(.W(W), .NCH(NCH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives nbits edges with load_en high, then one low edge; returns sampled after frame end.
    task automatic send_frame(input logic [NCH*W-1:0] val, input int nbits,
                              input logic [NCH-1:0] pflip);
        logic [NCH-1:0] par;
        busy_cnt = 0;
        for (int l = 0; l < NCH; l++) par[l] = (^val[l*W +: W]) ^ pflip[l];
        for (int k = 0; k < nbits; k++) begin
            bus.load_en = 1'b1;
            for (int l = 0; l < NCH; l++)
                bus.sdata[l] = (k < W) ? val[l*W + W-1-k] : par[l];
            @(posedge clk); #1;
            if (bus.busy) busy_cnt++;
        end
        bus.load_en = 1'b0;
        bus.sdata   = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        bus.load_en = 1'b0;
        bus.sdata   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_params", bus.params, 0);
        chk("rst_busy",   bus.busy, 0);
        chk("rst_upd",    bus.upd, 0);
        chk("rst_err",    bus.err, 0);
        chk("rst_stk",    bus.err_sticky, 0);
        rst_n = 1'b1;

        // Good frame: lane0=A5, lane1=3C, lane2=FF
        send_frame(24'hFF3CA5, FLEN, '0);
        chk("f1_params", bus.params, 24'hFF3CA5);
        chk("f1_upd",    bus.upd, 1);
        chk("f1_err",    bus.err, 0);
        chk("f1_stk",    bus.err_sticky, 0);
        chk("f1_busy",   bus.busy, 0);
        chk("f1_busyc",  busy_cnt, FLEN);
        @(posedge clk); #1;
        chk("f1_upd_drop", bus.upd, 0);

        // Short frame
        send_frame(24'h123456, 5, '0);
        chk("short_err",    bus.err, 1);
        chk("short_upd",    bus.upd, 0);
        chk("short_stk",    bus.err_sticky, 1);
        chk("short_params", bus.params, 24'hFF3CA5);
        @(posedge clk); #1;
        chk("short_err_drop", bus.err, 0);
        chk("short_stk_hold", bus.err_sticky, 1);

        send_frame(24'h010203, FLEN, '0);
        chk("f2_params", bus.params, 24'h010203);
        chk("f2_upd",    bus.upd, 1);
        chk("f2_stk",    bus.err_sticky, 0);
        @(posedge clk); #1;

        // Long frame: 10 edges high
        send_frame(24'hAAAAAA, 10, '0);
        chk("long_err",    bus.err, 1);
        chk("long_upd",    bus.upd, 0);
        chk("long_params", bus.params, 24'h010203);
        chk("long_busyc",  busy_cnt, 10);
        chk("long_stk",    bus.err_sticky, 1);
        @(posedge clk); #1;

        // One-cycle pulse
        send_frame(24'hFFFFFF, 1, '0);
        chk("pulse_err",    bus.err, 1);
        chk("pulse_params", bus.params, 24'h010203);
        @(posedge clk); #1;

        // Reset after 4 bits of a frame, asynchronous
        for (int k = 0; k < 4; k++) begin
            bus.load_en = 1'b1;
            bus.sdata   = 3'b101;
            @(posedge clk); #1;
        end
        chk("mid_busy_pre", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_params", bus.params, 0);
        chk("mid_busy",   bus.busy, 0);
        chk("mid_upd",    bus.upd, 0);
        chk("mid_err",    bus.err, 0);
        chk("mid_stk",    bus.err_sticky, 0);
        bus.load_en = 1'b0;
        bus.sdata   = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_frame(24'h112233, FLEN, '0);
        chk("post_rst_params", bus.params, 24'h112233);
        chk("post_rst_upd",    bus.upd, 1);

        // Back-to-back: only one low sample between frames
        send_frame(24'h445566, FLEN, '0);
        chk("b2b1_upd",    bus.upd, 1);
        chk("b2b1_params", bus.params, 24'h445566);
        send_frame(24'h778899, FLEN, '0);
        chk("b2b2_upd",    bus.upd, 1);
        chk("b2b2_params", bus.params, 24'h778899);
        chk("b2b2_err",    bus.err, 0);
        @(posedge clk); #1;

`ifdef PARITY_CHECK_EN
        // lane0=A5 has four ones: correct even-parity bit is 0
        send_frame(24'h0000A5, FLEN, '0);
        chk("par_ok_params", bus.params, 24'h0000A5);
        chk("par_ok_upd",    bus.upd, 1);
        @(posedge clk); #1;
        send_frame(24'h0000A5, FLEN, 3'b001);
        chk("par_bad_err",    bus.err, 1);
        chk("par_bad_upd",    bus.upd, 0);
        chk("par_bad_params", bus.params, 24'h0000A5);
        chk("par_bad_stk",    bus.err_sticky, 1);
        @(posedge clk); #1;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
